// File: rtl/ddr_ring_pkg.sv
// ddr_ring_pkg: shared constants, descriptor type and
// AR state encoding for the DDR packet ring controller.
package ddr_ring_pkg;

  localparam int BEAT_BYTES = 64;
  localparam int PAGE_BYTES = 4096;
  localparam int DESC_AW    = 31;

  typedef struct packed {
    logic [DESC_AW-1:0] addr;
    logic [7:0]         beats;
    logic [12:0]        charge;
  } desc_t;

  typedef enum logic {
    AR_IDLE,
    AR_WAIT
  } ar_state_e;

  // Round a byte count up to whole beats; 17 bits so
  // that 16'hFFFF cannot wrap to zero.
  function automatic logic [16:0] round_to_beat(
    input logic [15:0] len
  );
    logic [16:0] w_sum;
    w_sum = {1'b0, len} + 17'(BEAT_BYTES - 1);
    return w_sum & ~17'(BEAT_BYTES - 1);
  endfunction

endpackage

// File: rtl/ddr_ring_ctrl_alloc.sv
// ring_alloc: combinational round/skip/fit computation.
// In: i_ptr, i_len, i_used. Out: o_base, o_next, o_charge, o_beats, o_legal, o_fit.
module ring_alloc
  import ddr_ring_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 31,
  parameter int unsigned RING_BASE     = 0,
  parameter int unsigned RING_BYTES    = 32'h4000_0000,
  parameter int          MAX_PKT_BYTES = 1536
) (
  input  logic [ADDR_WIDTH-1:0] i_ptr,
  input  logic [15:0]           i_len,
  input  logic [ADDR_WIDTH:0]   i_used,
  output logic [ADDR_WIDTH-1:0] o_base,
  output logic [ADDR_WIDTH-1:0] o_next,
  output logic [12:0]           o_charge,
  output logic [7:0]            o_beats,
  output logic                  o_legal,
  output logic                  o_fit
);

  localparam int PGW = $clog2(PAGE_BYTES);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] L_END =
    AW1'(64'(RING_BASE) + 64'(RING_BYTES));
  localparam logic [ADDR_WIDTH-1:0] L_BASE =
    ADDR_WIDTH'(RING_BASE);

  logic [16:0]    w_rnd;
  logic [PGW:0]   w_off;
  logic           w_cross;
  logic [12:0]    w_skip;
  logic [AW1-1:0] w_sum;
  logic [AW1-1:0] w_nsum;

  assign w_rnd   = round_to_beat(i_len);
  assign w_off   = {1'b0, i_ptr[PGW-1:0]};
  // Ending exactly on a page boundary is not a crossing.
  assign w_cross = (17'(w_off) + w_rnd) > 17'(PAGE_BYTES);
  assign w_skip  = w_cross ? (13'(PAGE_BYTES) - w_off) : '0;

  assign w_sum  = {1'b0, i_ptr} + AW1'(w_skip);
  assign o_base = (w_sum == L_END) ? L_BASE
                                   : w_sum[ADDR_WIDTH-1:0];

  assign w_nsum = {1'b0, o_base} + AW1'(w_rnd);
  assign o_next = (w_nsum == L_END) ? L_BASE
                                    : w_nsum[ADDR_WIDTH-1:0];

  assign o_charge = w_rnd[12:0] + w_skip;
  assign o_beats  = w_rnd[13:6];
  assign o_legal  = (i_len != '0) &&
                    (i_len <= 16'(MAX_PKT_BYTES));
  assign o_fit    = ({1'b0, i_used} + (AW1 + 1)'(o_charge))
                    <= (AW1 + 1)'(RING_BYTES);

endmodule

// File: rtl/ddr_ring_ctrl.sv
// ddr_ring_ctrl: allocates, issues (AXI AR) and retires packet slots in a DDR ring.
// Ports: alloc req/ready/addr, commit pulse, AXI AR master, R monitor, CSR enable, status.
module ddr_ring_ctrl
  import ddr_ring_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 31,
  parameter int          DATA_WIDTH      = 512,
  parameter int          ID_WIDTH        = 4,
  parameter int unsigned RING_BASE       = 0,
  parameter int unsigned RING_BYTES      = 32'h4000_0000,
  parameter int          DESC_DEPTH      = 64,
  parameter int          MAX_OUTSTANDING = 8,
  parameter int          MAX_PKT_BYTES   = 1536
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_valid,
  input  logic [15:0]                 alloc_len,
  output logic                        alloc_ready,
  output logic [ADDR_WIDTH-1:0]       alloc_addr,
  input  logic                        commit_valid,
  output logic [ID_WIDTH-1:0]         m_axi_arid,
  output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic                        m_axi_rvalid,
  input  logic                        m_axi_rready,
  input  logic                        m_axi_rlast,
  input  logic                        ddr_rd_en,
  output logic [ADDR_WIDTH:0]         used_bytes,
  output logic [$clog2(DESC_DEPTH):0] pkt_pending,
  output logic                        err_sticky
);

  localparam int PW  = $clog2(DESC_DEPTH);
  localparam int IW  = PW + 1;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  logic [IW-1:0]         r_alloc_idx;
  logic [IW-1:0]         r_commit_idx;
  logic [IW-1:0]         r_issue_idx;
  logic [IW-1:0]         r_retire_idx;
  logic [ADDR_WIDTH-1:0] r_alloc_ptr;
  logic [AW1-1:0]        r_used;
  logic [OW-1:0]         r_outst;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  ar_state_e             r_state;
  ar_state_e             w_next_state;
  desc_t                 r_desc [DESC_DEPTH];

  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_next_ptr;
  logic [12:0]           w_charge;
  logic [7:0]            w_beats;
  logic                  w_legal;
  logic                  w_fit;
  logic                  w_full;
  logic                  w_alloc_hs;
  logic                  w_bad_req;
  logic                  w_commit_ok;
  logic                  w_commit_bad;
  logic                  w_ar_hs;
  logic                  w_rlast;
  logic                  w_retire;
  logic                  w_rlast_bad;
  logic                  w_start;
  logic                  w_load;
  logic                  w_arvalid;
  logic [AW1-1:0]        w_add;
  logic [AW1-1:0]        w_sub;
  desc_t                 w_iss_desc;
  desc_t                 w_ret_desc;

  ring_alloc #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RING_BASE    (RING_BASE),
    .RING_BYTES   (RING_BYTES),
    .MAX_PKT_BYTES(MAX_PKT_BYTES)
  ) u_alloc (
    .i_ptr   (r_alloc_ptr),
    .i_len   (alloc_len),
    .i_used  (r_used),
    .o_base  (w_base),
    .o_next  (w_next_ptr),
    .o_charge(w_charge),
    .o_beats (w_beats),
    .o_legal (w_legal),
    .o_fit   (w_fit)
  );

  assign w_full = (r_alloc_idx - r_retire_idx) == IW'(DESC_DEPTH);

  // Illegal requests are always accepted so they are consumed.
  assign alloc_ready = alloc_valid &
                       (~w_legal | (~w_full & w_fit));
  assign alloc_addr  = w_base;

  assign w_alloc_hs   = alloc_valid & alloc_ready & w_legal;
  assign w_bad_req    = alloc_valid & ~w_legal;
  assign w_commit_ok  = commit_valid & (r_commit_idx != r_alloc_idx);
  assign w_commit_bad = commit_valid & (r_commit_idx == r_alloc_idx);
  assign w_ar_hs      = w_arvalid & m_axi_arready;
  assign w_rlast      = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign w_retire     = w_rlast & (r_outst != '0);
  assign w_rlast_bad  = w_rlast & (r_outst == '0);

  assign w_iss_desc = r_desc[r_issue_idx[PW-1:0]];
  assign w_ret_desc = r_desc[r_retire_idx[PW-1:0]];

  assign w_add = w_alloc_hs ? AW1'(w_charge) : '0;
  assign w_sub = w_retire ? AW1'(w_ret_desc.charge) : '0;

  assign w_start = ddr_rd_en &
                   (r_issue_idx != r_commit_idx) &
                   (r_outst < OW'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= AR_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      AR_IDLE: if (w_start) w_next_state = AR_WAIT;
      AR_WAIT: if (m_axi_arready) w_next_state = AR_IDLE;
      default: w_next_state = AR_IDLE;
    endcase
  end

  always_comb begin
    w_arvalid = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      AR_IDLE: w_load = w_start;
      AR_WAIT: w_arvalid = 1'b1;
      default: w_arvalid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_alloc_hs) begin
      r_desc[r_alloc_idx[PW-1:0]] <= '{
        addr:   DESC_AW'(w_base),
        beats:  w_beats,
        charge: w_charge
      };
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc_idx  <= '0;
      r_commit_idx <= '0;
      r_issue_idx  <= '0;
      r_retire_idx <= '0;
      r_alloc_ptr  <= ADDR_WIDTH'(RING_BASE);
      r_used       <= '0;
      r_outst      <= '0;
      r_err        <= 1'b0;
      r_araddr     <= '0;
      r_arlen      <= '0;
    end else begin
      if (w_alloc_hs) begin
        r_alloc_idx <= r_alloc_idx + 1'b1;
        r_alloc_ptr <= w_next_ptr;
      end
      if (w_commit_ok) r_commit_idx <= r_commit_idx + 1'b1;
      if (w_ar_hs)     r_issue_idx  <= r_issue_idx + 1'b1;
      if (w_retire)    r_retire_idx <= r_retire_idx + 1'b1;
      r_used <= r_used + w_add - w_sub;
      if (w_ar_hs & ~w_retire) begin
        r_outst <= r_outst + 1'b1;
      end else if (w_retire & ~w_ar_hs) begin
        r_outst <= r_outst - 1'b1;
      end
      if (w_load) begin
        r_araddr <= ADDR_WIDTH'(w_iss_desc.addr);
        r_arlen  <= w_iss_desc.beats - 8'd1;
      end
      if (w_bad_req | w_commit_bad | w_rlast_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = w_arvalid;
  assign used_bytes    = r_used;
  assign pkt_pending   = r_commit_idx - r_issue_idx;
  assign err_sticky    = r_err;

endmodule

// File: tb/tb_ddr_ring_ctrl.sv
// tb_ddr_ring_ctrl: directed table + sequence bench for ddr_ring_ctrl
// on an 8 KB ring (RING_BYTES=8192), other parameters default.
module tb_ddr_ring_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [15:0] alloc_len;
  logic        alloc_ready;
  logic [30:0] alloc_addr;
  logic        commit_valid;
  logic [3:0]  m_axi_arid;
  logic [30:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        m_axi_rlast;
  logic        ddr_rd_en;
  logic [31:0] used_bytes;
  logic [6:0]  pkt_pending;
  logic        err_sticky;

  int n_vec = 0;
  int n_bad = 0;
  int n_ar;
  logic [30:0] cap_addr [16];
  logic [7:0]  cap_len  [16];

  typedef struct {
    logic [15:0] len;
    logic        rdy;
    logic        chk_addr;
    logic [30:0] addr;
    logic [31:0] used;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  ddr_ring_ctrl #(.RING_BYTES(8192)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_len    (alloc_len),
    .alloc_ready  (alloc_ready),
    .alloc_addr   (alloc_addr),
    .commit_valid (commit_valid),
    .m_axi_arid   (m_axi_arid),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axi_rlast  (m_axi_rlast),
    .ddr_rd_en    (ddr_rd_en),
    .used_bytes   (used_bytes),
    .pkt_pending  (pkt_pending),
    .err_sticky   (err_sticky)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 0; alloc_len = 0; commit_valid = 0;
    m_axi_arready = 0; m_axi_rvalid = 0;
    m_axi_rready = 0; m_axi_rlast = 0; ddr_rd_en = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [15:0] len,
                          input logic [30:0] exp_addr);
    alloc_valid = 1; alloc_len = len;
    @(negedge clk);
    chk("alloc_ready", alloc_ready, 1'b1);
    chk("alloc_addr", alloc_addr, exp_addr);
    tick();
    alloc_valid = 0;
  endtask

  task automatic commit();
    commit_valid = 1;
    tick();
    commit_valid = 0;
  endtask

  task automatic rlast_pulse();
    m_axi_rvalid = 1; m_axi_rready = 1; m_axi_rlast = 1;
    tick();
    m_axi_rvalid = 0; m_axi_rready = 0; m_axi_rlast = 0;
  endtask

  task automatic run_ar(input int cycles, output int n);
    n = 0;
    ddr_rd_en = 1; m_axi_arready = 1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (m_axi_arvalid && n < 16) begin
        cap_addr[n] = m_axi_araddr;
        cap_len[n]  = m_axi_arlen;
        n++;
      end
      tick();
    end
    ddr_rd_en = 0; m_axi_arready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [30:0] ea [4];
    logic [7:0]  el [4];
    logic [30:0] h_addr;
    logic [7:0]  h_len;
    bit          seen;

    tbl[0]  = '{16'd1536, 1'b1, 1'b1, 31'h000,  32'd1536, 1'b0};
    tbl[1]  = '{16'd1536, 1'b1, 1'b1, 31'h600,  32'd3072, 1'b0};
    tbl[2]  = '{16'd896,  1'b1, 1'b1, 31'hC00,  32'd3968, 1'b0};
    tbl[3]  = '{16'd1500, 1'b1, 1'b1, 31'h1000, 32'd5632, 1'b0};
    tbl[4]  = '{16'd0,    1'b1, 1'b0, 31'h0,    32'd5632, 1'b1};
    tbl[5]  = '{16'd1600, 1'b1, 1'b0, 31'h0,    32'd5632, 1'b1};
    tbl[6]  = '{16'd64,   1'b1, 1'b1, 31'h1600, 32'd5696, 1'b1};
    tbl[7]  = '{16'd1,    1'b1, 1'b1, 31'h1640, 32'd5760, 1'b1};
    tbl[8]  = '{16'd1536, 1'b1, 1'b1, 31'h1680, 32'd7296, 1'b1};
    tbl[9]  = '{16'd832,  1'b1, 1'b1, 31'h1C80, 32'd8128, 1'b1};
    tbl[10] = '{16'd65,   1'b0, 1'b0, 31'h0,    32'd8128, 1'b1};

    // Reset state and a single small packet end to end.
    do_reset();
    @(negedge clk);
    chk("rst alloc_ready", alloc_ready, 1'b0);
    chk("rst arvalid", m_axi_arvalid, 1'b0);
    chk("rst used", used_bytes, 32'd0);
    chk("rst pending", pkt_pending, 7'd0);
    chk("rst err", err_sticky, 1'b0);
    chk("rst araddr", m_axi_araddr, 31'd0);
    chk("rst arlen", m_axi_arlen, 8'd0);
    tick();
    do_alloc(16'd100, 31'h0);
    @(negedge clk);
    chk("t1 used", used_bytes, 32'd128);
    tick();
    commit();
    @(negedge clk);
    chk("t1 pending", pkt_pending, 7'd1);
    tick();
    run_ar(10, n_ar);
    chk("t1 ar count", 64'(n_ar), 64'd1);
    chk("t1 araddr", cap_addr[0], 31'h0);
    chk("t1 arlen", cap_len[0], 8'd1);
    chk("t1 arsize", m_axi_arsize, 3'd6);
    chk("t1 arburst", m_axi_arburst, 2'b01);
    chk("t1 arid", m_axi_arid, 4'd0);
    rlast_pulse();
    @(negedge clk);
    chk("t1 used freed", used_bytes, 32'd0);
    chk("t1 err", err_sticky, 1'b0);
    tick();

    // Table: skip, illegal lengths, fill to RING-64.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      alloc_valid = 1; alloc_len = tbl[i].len;
      @(negedge clk);
      chk($sformatf("tbl%0d ready", i), alloc_ready, tbl[i].rdy);
      if (tbl[i].chk_addr)
        chk($sformatf("tbl%0d addr", i), alloc_addr, tbl[i].addr);
      tick();
      alloc_valid = 0;
      @(negedge clk);
      chk($sformatf("tbl%0d used", i), used_bytes, tbl[i].used);
      chk($sformatf("tbl%0d err", i), err_sticky, tbl[i].err);
      tick();
    end
    for (int i = 0; i < 4; i++) commit();
    @(negedge clk);
    chk("tbl pending", pkt_pending, 7'd4);
    tick();
    ea[0] = 31'h000;  el[0] = 8'd23;
    ea[1] = 31'h600;  el[1] = 8'd23;
    ea[2] = 31'hC00;  el[2] = 8'd13;
    ea[3] = 31'h1000; el[3] = 8'd23;
    run_ar(20, n_ar);
    chk("tbl ar count", 64'(n_ar), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tbl ar%0d addr", i), cap_addr[i], ea[i]);
      chk($sformatf("tbl ar%0d len", i), cap_len[i], el[i]);
    end
    // Blocked 65-byte request unblocks after one retire.
    alloc_valid = 1; alloc_len = 16'd65;
    m_axi_rvalid = 1; m_axi_rready = 1; m_axi_rlast = 1;
    @(negedge clk);
    chk("full ready before", alloc_ready, 1'b0);
    tick();
    m_axi_rvalid = 0; m_axi_rready = 0; m_axi_rlast = 0;
    @(negedge clk);
    chk("full ready after", alloc_ready, 1'b1);
    chk("full wrap addr", alloc_addr, 31'h0);
    tick();
    alloc_valid = 0;
    @(negedge clk);
    chk("full used", used_bytes, 32'd6784);
    tick();

    // Skip that lands on the ring end wraps to the base.
    do_reset();
    do_alloc(16'd1536, 31'h000);
    do_alloc(16'd1536, 31'h600);
    do_alloc(16'd1024, 31'hC00);
    do_alloc(16'd1536, 31'h1000);
    do_alloc(16'd1536, 31'h1600);
    commit(); commit();
    run_ar(12, n_ar);
    chk("wrap ar count", 64'(n_ar), 64'd2);
    rlast_pulse(); rlast_pulse();
    @(negedge clk);
    chk("wrap used", used_bytes, 32'd4096);
    tick();
    do_alloc(16'd1536, 31'h0);
    @(negedge clk);
    chk("wrap used after", used_bytes, 32'd6656);
    tick();

    // Outstanding limit of 8.
    do_reset();
    for (int i = 0; i < 10; i++) do_alloc(16'd64, 31'(i * 64));
    for (int i = 0; i < 10; i++) commit();
    @(negedge clk);
    chk("outst pending", pkt_pending, 7'd10);
    tick();
    run_ar(40, n_ar);
    chk("outst ar count", 64'(n_ar), 64'd8);
    @(negedge clk);
    chk("outst pending2", pkt_pending, 7'd2);
    tick();
    rlast_pulse();
    run_ar(10, n_ar);
    chk("outst 9th ar", 64'(n_ar), 64'd1);
    chk("outst 9th addr", cap_addr[0], 31'd512);
    @(negedge clk);
    chk("outst used", used_bytes, 32'd576);
    tick();

    // AR held stable under backpressure and ddr_rd_en drop.
    do_reset();
    do_alloc(16'd64, 31'h0);
    do_alloc(16'd128, 31'h40);
    commit(); commit();
    ddr_rd_en = 1; m_axi_arready = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_axi_arvalid) seen = 1;
      else tick();
    end
    chk("hold arvalid seen", seen, 1'b1);
    h_addr = m_axi_araddr; h_len = m_axi_arlen;
    chk("hold araddr", h_addr, 31'h0);
    chk("hold arlen", h_len, 8'd0);
    tick();
    ddr_rd_en = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold arvalid", m_axi_arvalid, 1'b1);
      chk("hold araddr stable", m_axi_araddr, 31'h0);
      chk("hold arlen stable", m_axi_arlen, 8'd0);
      tick();
    end
    m_axi_arready = 1;
    tick();
    m_axi_arready = 0;
    @(negedge clk);
    chk("hold arvalid drop", m_axi_arvalid, 1'b0);
    chk("hold pending", pkt_pending, 7'd1);
    tick();
    run_ar(10, n_ar);
    chk("hold 2nd count", 64'(n_ar), 64'd1);
    chk("hold 2nd addr", cap_addr[0], 31'h40);
    chk("hold 2nd len", cap_len[0], 8'd1);

    // Error cases.
    do_reset();
    rlast_pulse();
    @(negedge clk);
    chk("err rlast", err_sticky, 1'b1);
    chk("err rlast used", used_bytes, 32'd0);
    tick();
    do_reset();
    commit();
    @(negedge clk);
    chk("err commit", err_sticky, 1'b1);
    chk("err commit pend", pkt_pending, 7'd0);
    tick();
    do_reset();
    alloc_valid = 1; alloc_len = 16'd0;
    @(negedge clk);
    chk("err len0 ready", alloc_ready, 1'b1);
    tick();
    alloc_len = 16'd1600;
    @(negedge clk);
    chk("err len1600 ready", alloc_ready, 1'b1);
    tick();
    alloc_valid = 0;
    commit();
    @(negedge clk);
    chk("err illegal sticky", err_sticky, 1'b1);
    chk("err illegal used", used_bytes, 32'd0);
    chk("err no desc", pkt_pending, 7'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_ring_ctrl.md
Name: ddr_ring_ctrl

Overview:
- Allocates, sequences and frees packet slots in a DDR circular buffer that sits between the ingress write path and the egress read path.
- The ingress writer requests space for each packet and receives a burst base address. It reports the commit once the B response arrives.
- The controller issues one AXI4 read burst per committed packet to the DDR read channel, gated by ddr_rd_en and an outstanding-read limit.
- When the last read beat of each packet arrives, the controller retires the packet and frees its space.

Parameters:
- ADDR_WIDTH, 31, AXI address width.
- DATA_WIDTH, 512, AXI data width. BEAT_BYTES = DATA_WIDTH/8 = 64.
- ID_WIDTH, 4, AXI ID width. arid is tied to 0.
- RING_BASE, 0, ring start byte address. Must be 4 KB aligned.
- RING_BYTES, 2**30, ring size in bytes. Must be a multiple of 4096.
- DESC_DEPTH, 64, descriptor slots. Power of 2.
- MAX_OUTSTANDING, 8, maximum issued-but-unretired read bursts.
- MAX_PKT_BYTES, 1536, largest legal request length.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alloc_valid  in  1  space request
- alloc_len  in  16  packet bytes
- alloc_ready  out  1  request accepted this cycle
- alloc_addr  out  ADDR_WIDTH  burst base address; valid when alloc_valid & alloc_ready
- commit_valid  in  1  pulse: oldest allocated packet has its B response
- m_axi_arid  out  ID_WIDTH  always 0
- m_axi_araddr  out  ADDR_WIDTH  burst address
- m_axi_arlen  out  8  beats-1
- m_axi_arsize  out  3  log2(BEAT_BYTES)
- m_axi_arburst  out  2  2'b01 (INCR)
- m_axi_arvalid  out  1  read request valid
- m_axi_arready  in  1  read request accepted
- m_axi_rvalid  in  1  monitored only
- m_axi_rready  in  1  monitored only
- m_axi_rlast  in  1  monitored only
- ddr_rd_en  in  1  CSR read enable
- used_bytes  out  ADDR_WIDTH+1  bytes charged in the ring, including skipped padding
- pkt_pending  out  $clog2(DESC_DEPTH)+1  committed but not yet issued
- err_sticky  out  1  illegal request, commit underflow, or retire underflow

Behaviour:
- Reset values:
  - alloc_ready=0, m_axi_arvalid=0, used_bytes=0, pkt_pending=0, err_sticky=0.
  - alloc_ptr=RING_BASE. All four descriptor indices = 0. Outstanding count = 0.
  - AR address/len outputs = 0.
- Rounding: rnd = ceil(alloc_len/64)*64, computed with 17-bit intermediate width. Burst length = rnd/64 - 1.
- Skip rule:
  - If alloc_ptr + rnd would cross a 4 KB boundary, the base moves to the next 4 KB boundary, wrapping to RING_BASE at RING_BASE+RING_BYTES.
  - skip = bytes jumped. The packet is charged rnd + skip.
- Descriptor ring: fields addr, beats, charge. Four indices:
  - alloc: incremented on an alloc handshake.
  - commit: incremented on commit_valid.
  - issue: incremented on an AR handshake.
  - retire: incremented on an rvalid&rready&rlast handshake.
  - Required ordering: retire ≤ issue ≤ commit ≤ alloc.
- alloc_ready (combinational):
  - Asserted when alloc_valid is high, the request is legal, the descriptor ring is not full, and used_bytes + rnd + skip ≤ RING_BYTES.
  - On a legal handshake: alloc_addr = skipped base, descriptor written, alloc_ptr = base + rnd (wraps), used_bytes += charge.
- Illegal request (alloc_len = 0 or > MAX_PKT_BYTES):
  - alloc_ready=1 for one cycle; the request is consumed.
  - No descriptor is created; err_sticky is set.
- commit_valid when commit == alloc: ignored, err_sticky set.
- AR issue state machine, AR_IDLE → AR_WAIT:
  - Leave AR_IDLE when ddr_rd_en & (issue != commit) & outstanding < MAX_OUTSTANDING.
  - Load araddr/arlen from the descriptor at issue and assert arvalid the next cycle.
  - In AR_WAIT, arvalid, araddr and arlen are held until arready.
  - On the handshake: issue++, outstanding++, return to AR_IDLE. Issue rate is one burst per 2 cycles maximum.
  - Dropping ddr_rd_en in AR_WAIT does not withdraw arvalid.
- Retire:
  - On an rlast handshake: used_bytes -= charge[retire], retire++, outstanding--.
  - AR handshake and retire in the same cycle leave outstanding unchanged.
  - An rlast with outstanding == 0 is ignored and sets err_sticky; this also covers stray beats after reset.
- Simultaneous alloc and retire: used_bytes is updated by +charge - freed in the same cycle.
- pkt_pending = commit - issue, computed with index widths of $clog2(DESC_DEPTH)+1.

Decomposition:
- Package ddr_ring_pkg:
  - BEAT_BYTES and PAGE_BYTES = 4096.
  - Typedef desc_t {addr, beats[7:0], charge[12:0]}.
  - Typedef ar_state_e.
  - Function round_to_beat().
- Sub-module ring_alloc: combinational skip/round/fit computation. Kept separate so it can be unit-tested.

Test Plan:
- alloc_len=100 at alloc_ptr=0 → alloc_addr=0x0, charge 128. Commit with ddr_rd_en=1 → AR addr=0x0, arlen=1. rlast handshake → used_bytes=0.
- alloc_ptr=0xF80, alloc_len=1500 → base skips to 0x1000 (skip 128, rnd 1536). used_bytes += 1664, arlen=23.
- RING_BYTES=8192, alloc_ptr=0x1C00, alloc_len=1536 → base wraps to 0x0, charge 2560.
- Fill to used_bytes=RING_BYTES-64, then alloc_len=65 → alloc_ready=0. One retire frees 1536 → next cycle alloc_ready=1.
- ddr_rd_en=1 with 10 committed packets and arready always 1, no rlast → exactly 8 AR handshakes. The 9th issues only after an rlast.
- Hold arready=0 for 5 cycles and drop ddr_rd_en → arvalid, araddr and arlen stay stable until arready.
- alloc_len=0, then alloc_len=1600, then rlast with outstanding=0 → err_sticky=1, no descriptors created, used_bytes unchanged.
